key_filter_repeat: RTL and testbench
====================================

// Module: key_filter_repeat
// PURPOSE
//  Front-end for one mechanical push-key on the STEP board.
//  Synchronises the raw pin, debounces it, and emits a single-cycle key_pulse per confirmed press.
//  key_pulse directly drives the increment enable of the downstream 0-99 counter/display stage.
//  Optional auto-repeat generates extra pulses while the key is held.
// PARAMETERS
//  DEBOUNCE_CYCLES  240000   stable cycles needed to accept a level change (20 ms @ 12 MHz); legal range 2..2^CNT_W-1
//  HOLD_CYCLES      6000000  cycles in HELD before the first repeat pulse (0.5 s); used only with AUTO_REPEAT_EN
//  REPEAT_CYCLES    1200000  cycles between repeat pulses (100 ms); used only with AUTO_REPEAT_EN
//  CNT_W            24       width of internal counters; must hold the largest of the three cycle parameters
// PORTS
//  clk        in   1  system clock (12 MHz)
//  rst        in   1  synchronous reset, active-low
//  key        in   1  raw key pin, asynchronous, active-low (0 = pressed)
//  key_pulse  out  1  one-cycle high per accepted press (and per repeat)
//  key_state  out  1  debounced level, 1 = pressed
// BEHAVIOUR
//  Reset, sampled on posedge clk with rst==0:
//   - sync flops = 1 (released)
//   - FSM = IDLE
//   - all counters = 0
//   - key_pulse = 0, key_state = 0
//  Synchroniser: two flops, ks0 <= key, ks1 <= ks0. The FSM uses only ks1.
//  FSM states and transitions:
//   - IDLE: if ks1==0 -> PRESS_WAIT with cnt=0.
//   - PRESS_WAIT:
//     - ks1==1 -> IDLE (bounce rejected, no pulse).
//     - else cnt++.
//     - at cnt==DEBOUNCE_CYCLES-1 -> HELD; key_pulse=1 for exactly that cycle; key_state=1; hold_cnt=0.
//   - HELD:
//     - ks1==1 -> RELEASE_WAIT with cnt=0.
//     - else hold_cnt advances (repeat only).
//   - RELEASE_WAIT:
//     - ks1==0 -> HELD with no pulse; hold_cnt is kept, not cleared.
//     - else cnt++.
//     - at cnt==DEBOUNCE_CYCLES-1 -> IDLE, key_state=0.
//  Latency:
//   - Input going low at edge T and held stable gives key_pulse high in cycle T+2+DEBOUNCE_CYCLES.
//   - key_state rises in the same cycle.
//  Pulse and state rules:
//   - key_pulse is registered and never high for two consecutive cycles.
//   - key_pulse is never high outside the entry into HELD or a repeat event.
//   - A press shorter than DEBOUNCE_CYCLES produces no pulse.
//   - A release glitch shorter than DEBOUNCE_CYCLES produces no second pulse.
//  Counter rules:
//   - Counters are unsigned CNT_W bits.
//   - Counters are compared for equality only and never wrap, because states exit at the terminal count.
//  Reset mid-operation:
//   - Immediate return to the reset values above.
//   - A key held low through reset release is treated as a new press: exactly one pulse after debounce.
//  Simultaneous events: rst==0 overrides everything. A key edge on the terminal-count cycle is honoured on the next cycle.
// CONFIGURATION
//  Macro AUTO_REPEAT_EN:
//   - Defined:
//     - In HELD, hold_cnt counts up.
//     - At hold_cnt==HOLD_CYCLES-1: key_pulse=1 and the repeat phase starts with rep_cnt=0.
//     - Then key_pulse=1 each time rep_cnt==REPEAT_CYCLES-1, after which rep_cnt resets to 0.
//     - Leaving HELD for IDLE (via RELEASE_WAIT) clears hold_cnt, rep_cnt and the repeat phase.
//   - Undefined:
//     - hold_cnt and rep_cnt are not synthesised.
//     - HELD emits no pulses.
//     - Exactly one pulse per press.
// TESTING
//  Sim parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
//  1. Reset: rst=0 for 3 cycles with key=1 -> key_pulse=0, key_state=0 throughout; no pulse for 50 cycles after release.
//  2. Clean press: key=0 from edge T, held 30 cycles -> one key_pulse exactly at cycle T+6; key_state=1 from T+6; no other pulse (macro undefined).
//  3. Bounce: key toggles 0/1 every 2 cycles for 20 cycles, then stays 1 -> zero pulses, key_state stays 0.
//  4. Release glitch: stable press accepted, then key=1 for 2 cycles, then 0 again -> no second pulse; key_state stays 1.
//  5. Reset mid-press: reset pulse while in HELD with key still 0 -> outputs 0 during reset; one pulse 6 cycles after rst returns to 1.
//  6. AUTO_REPEAT_EN defined, key held 60 cycles from T:
//     - pulses at T+6 (press) and T+26 (hold)
//     - repeat pulses at T+34, T+42, T+50, T+58
//     - total 6 pulses

Source files
------------

// File: rtl/key_filter_repeat.sv
// Single-key front-end: two-flop synchroniser, debounce FSM, one-cycle press pulse.
// Define AUTO_REPEAT_EN to add hold/repeat pulses while the key stays pressed.
module key_filter_repeat #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned HOLD_CYCLES     = 6000000,
  parameter int unsigned REPEAT_CYCLES   = 1200000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_pulse,
  output logic key_state
);

  localparam longint unsigned MAX_CNT = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) > MAX_CNT ||
      64'(HOLD_CYCLES) > MAX_CNT || 64'(REPEAT_CYCLES) > MAX_CNT) begin : g_bad_param
    $error("key_filter_repeat: cycle parameter out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT
  } state_t;

  logic             r_ks0, r_ks1;
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_pulse, w_pulse_nx;
  logic             r_kstate, w_kstate_nx;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nx;
  logic [CNT_W-1:0] r_rep_cnt, w_rep_cnt_nx;
  logic             r_rep_phase, w_rep_phase_nx;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ks0 <= 1'b1;
      r_ks1 <= 1'b1;
    end else begin
      r_ks0 <= key;
      r_ks1 <= r_ks0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
      r_kstate <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_hold_cnt  <= '0;
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_pulse  <= w_pulse_nx;
      r_kstate <= w_kstate_nx;
`ifdef AUTO_REPEAT_EN
      r_hold_cnt  <= w_hold_cnt_nx;
      r_rep_cnt   <= w_rep_cnt_nx;
      r_rep_phase <= w_rep_phase_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_pulse_nx  = 1'b0;
    w_kstate_nx = r_kstate;
`ifdef AUTO_REPEAT_EN
    w_hold_cnt_nx  = r_hold_cnt;
    w_rep_cnt_nx   = r_rep_cnt;
    w_rep_phase_nx = r_rep_phase;
`endif
    case (r_state)
      S_IDLE: begin
        if (!r_ks1) begin
          w_state_nx = S_PRESS_WAIT;
          w_cnt_nx   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (r_ks1) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nx  = S_HELD;
          w_pulse_nx  = 1'b1;
          w_kstate_nx = 1'b1;
`ifdef AUTO_REPEAT_EN
          w_hold_cnt_nx  = '0;
          w_rep_cnt_nx   = '0;
          w_rep_phase_nx = 1'b0;
`endif
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (r_ks1) begin
          w_state_nx = S_RELEASE_WAIT;
          w_cnt_nx   = '0;
        end else begin
`ifdef AUTO_REPEAT_EN
          // hold_cnt stops at its terminal value once the repeat phase owns pulse timing
          if (!r_rep_phase) begin
            if (r_hold_cnt == HOLD_LAST) begin
              w_pulse_nx     = 1'b1;
              w_rep_phase_nx = 1'b1;
              w_rep_cnt_nx   = '0;
            end else begin
              w_hold_cnt_nx = r_hold_cnt + 1'b1;
            end
          end else if (r_rep_cnt == REP_LAST) begin
            w_pulse_nx   = 1'b1;
            w_rep_cnt_nx = '0;
          end else begin
            w_rep_cnt_nx = r_rep_cnt + 1'b1;
          end
`endif
        end
      end
      S_RELEASE_WAIT: begin
        if (!r_ks1) begin
          w_state_nx = S_HELD;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nx  = S_IDLE;
          w_kstate_nx = 1'b0;
`ifdef AUTO_REPEAT_EN
          w_hold_cnt_nx  = '0;
          w_rep_cnt_nx   = '0;
          w_rep_phase_nx = 1'b0;
`endif
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign key_pulse = r_pulse;
  assign key_state = r_kstate;

endmodule

// File: tb/tb_key_filter_repeat.sv
// Bench for key_filter_repeat: directed sequences, a press-length table and random
// stimulus checked cycle by cycle against a run-length reference model.
module tb_key_filter_repeat;
  localparam int unsigned D = 4;
  localparam int unsigned H = 20;
  localparam int unsigned R = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key = 1'b1;
  logic key_pulse, key_state;

  always #5 clk = ~clk;

  key_filter_repeat #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .key_pulse(key_pulse),
    .key_state(key_state)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: level flips after D+1 consecutive synchronised samples opposing it;
  // repeats fire on the H-th, H+R-th, ... uninterrupted low sample while pressed.
  bit h0 = 1'b1, h1 = 1'b1, s;
  int m_lvl = 0, m_run = 0, m_adv = 0, m_pulse = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      h0 = 1'b1; h1 = 1'b1;
      m_lvl = 0; m_run = 0; m_adv = 0; m_pulse = 0;
    end else begin
      s = h1; h1 = h0; h0 = key;
      m_pulse = 0;
      if (m_lvl == 0) begin
        if (!s) begin
          m_run++;
          if (m_run == D + 1) begin
            m_lvl = 1; m_run = 0; m_adv = 0; m_pulse = 1;
          end
        end else m_run = 0;
      end else begin
        if (s) begin
          m_run++;
          if (m_run == D + 1) begin
            m_lvl = 0; m_run = 0;
          end
        end else if (m_run > 0) begin
          m_run = 0;
        end else begin
          m_adv++;
`ifdef AUTO_REPEAT_EN
          if (m_adv >= H && (m_adv - H) % R == 0) m_pulse = 1;
`endif
        end
      end
    end
    mon_en = 1'b1;
  end

  int pulse_q[$];
  int rise_q[$];
  bit prev_state = 1'b0, prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("model_pulse", int'(key_pulse), m_pulse);
      check("model_state", int'(key_state), m_lvl);
      check("no_double_pulse", int'(key_pulse & prev_pulse), 0);
      if (key_pulse === 1'b1) pulse_q.push_back(cyc);
      if (key_state === 1'b1 && !prev_state) rise_q.push_back(cyc);
      prev_state = (key_state === 1'b1);
      prev_pulse = (key_pulse === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int low_len;
    int exp_plain;
    int exp_rep;
  } vec_t;
  vec_t tbl[10];

  int t0;
  int exp_n;
  int rep_at[6];

  initial begin
    tbl = '{'{1, 0, 0}, '{2, 0, 0}, '{4, 0, 0}, '{5, 1, 1}, '{6, 1, 1},
            '{12, 1, 1}, '{24, 1, 1}, '{25, 1, 2}, '{33, 1, 3}, '{40, 1, 3}};
    rep_at = '{6, 26, 34, 42, 50, 58};

    rst = 1'b0; key = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_pulse", int'(key_pulse), 0);
      check("reset_state", int'(key_state), 0);
    end
    rst = 1'b1;
    pulse_q.delete(); rise_q.delete();
    wait_n(50);
    check("idle_no_pulse", pulse_q.size(), 0);

    // clean press
    key = 1'b0; t0 = cyc + 1;
    wait_n(30);
    key = 1'b1;
    wait_n(15);
`ifdef AUTO_REPEAT_EN
    exp_n = 2;
`else
    exp_n = 1;
`endif
    check("press_count", pulse_q.size(), exp_n);
    check("press_latency", pulse_q.size() > 0 ? pulse_q[0] - t0 : -1, 6);
    check("state_rise_latency", rise_q.size() > 0 ? rise_q[0] - t0 : -1, 6);
    check("press_released", int'(key_state), 0);
    pulse_q.delete(); rise_q.delete();

    // bounce
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_n(2);
    end
    key = 1'b1;
    wait_n(12);
    check("bounce_pulses", pulse_q.size(), 0);
    check("bounce_state_rises", rise_q.size(), 0);
    pulse_q.delete(); rise_q.delete();

    // release glitch
    key = 1'b0;
    wait_n(10);
    key = 1'b1;
    wait_n(2);
    key = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("glitch_state", int'(key_state), 1);
    end
    wait_n(5);
    key = 1'b1;
    wait_n(15);
    check("glitch_pulses", pulse_q.size(), 1);
    check("glitch_released", int'(key_state), 0);

    // reset while held
    key = 1'b0;
    wait_n(12);
    check("pre_reset_held", int'(key_state), 1);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midreset_pulse", int'(key_pulse), 0);
      check("midreset_state", int'(key_state), 0);
    end
    pulse_q.delete();
    rst = 1'b1; t0 = cyc + 1;
    wait_n(15);
    key = 1'b1;
    wait_n(15);
    check("postreset_count", pulse_q.size(), 1);
    check("postreset_latency", pulse_q.size() > 0 ? pulse_q[0] - t0 : -1, 6);
    pulse_q.delete();

    // long hold
    key = 1'b0; t0 = cyc + 1;
    wait_n(60);
    key = 1'b1;
    wait_n(15);
`ifdef AUTO_REPEAT_EN
    check("hold_count", pulse_q.size(), 6);
    for (int k = 0; k < 6; k++)
      check("hold_pulse_time", pulse_q.size() > k ? pulse_q[k] - t0 : -1, rep_at[k]);
`else
    check("hold_count", pulse_q.size(), 1);
    check("hold_pulse_time", pulse_q.size() > 0 ? pulse_q[0] - t0 : -1, 6);
`endif

    // press-length table
    for (int i = 0; i < 10; i++) begin
      pulse_q.delete();
      key = 1'b0;
      wait_n(tbl[i].low_len);
      key = 1'b1;
      wait_n(12);
`ifdef AUTO_REPEAT_EN
      check($sformatf("tbl_pulses_len%0d", tbl[i].low_len), pulse_q.size(), tbl[i].exp_rep);
`else
      check($sformatf("tbl_pulses_len%0d", tbl[i].low_len), pulse_q.size(), tbl[i].exp_plain);
`endif
      check("tbl_state_after", int'(key_state), 0);
    end

    // random segments with occasional resets
    for (int i = 0; i < 80; i++) begin
      key = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
      wait_n(($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 8)));
    end
    rst = 1'b1; key = 1'b1;
    wait_n(12);
    check("final_state", int'(key_state), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
